// File: rtl/calc_control_unit.sv
// rtl/calc_control_unit.sv - Moore sequencer for the calculator datapath.
// Optional DONE_HOLD_EN: hold the done state while go stays high.
module calc_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic [1:0] WA,
  output logic       WE,
  output logic [1:0] RAA,
  output logic       REA,
  output logic [1:0] RAB,
  output logic       REB,
  output logic [1:0] C,
  output logic       s2,
  output logic [3:0] CS,
  output logic       done
);

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [14:0] ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S0;
    else     state <= state_next;
  end

  // ctrl packs {s1,WA,WE,RAA,REA,RAB,REB,C,s2,done}
  always_comb begin
    state_next = S0;
    ctrl       = '0;
    case (state)
      S0: state_next = go ? S1 : S0;
      S1: begin state_next = S2; ctrl = 15'b110110000000000; end
      S2: begin state_next = S3; ctrl = 15'b101010000000000; end
      S3: begin
        ctrl = 15'b000000111010000;
        case (op)
          2'b11:   state_next = S4;
          2'b10:   state_next = S5;
          2'b01:   state_next = S6;
          default: state_next = S7;
        endcase
      end
      S4: begin state_next = S8; ctrl = 15'b001110000001100; end
      S5: begin state_next = S8; ctrl = 15'b001110000001000; end
      // S7 (op=00) deliberately drives the same ALU code as S6
      S6: begin state_next = S8; ctrl = 15'b001110000000100; end
      S7: begin state_next = S8; ctrl = 15'b001110000000100; end
      S8: begin
`ifdef DONE_HOLD_EN
        state_next = go ? S8 : S0;
`else
        state_next = S0;
`endif
        ctrl = 15'b000000000000011;
      end
      default: begin state_next = S0; ctrl = '0; end
    endcase
  end

  assign {s1, WA, WE, RAA, REA, RAB, REB, C, s2, done} = ctrl;
  assign CS = state;

endmodule

// File: tb/tb_calc_control_unit.sv
// tb/tb_calc_control_unit.sv - randomized self-checking bench for calc_control_unit.
module tb_calc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [1:0] op;
  logic [1:0] s1, WA, RAA, RAB, C;
  logic       WE, REA, REB, s2, done;
  logic [3:0] CS;
  logic [14:0] vec;

  int errors = 0;
  int checks = 0;
  int ms = 0;
  int exp_done_edges = 0;
  int obs_done_edges = 0;

  calc_control_unit dut (
    .clk(clk), .rst(rst), .go(go), .op(op),
    .s1(s1), .WA(WA), .WE(WE), .RAA(RAA), .REA(REA),
    .RAB(RAB), .REB(REB), .C(C), .s2(s2), .CS(CS), .done(done)
  );

  always #5 clk = ~clk;

  assign vec = {s1, WA, WE, RAA, REA, RAB, REB, C, s2, done};

  always @(posedge done) obs_done_edges++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control vector per state, straight from the state table
  function automatic logic [14:0] exp_vec(input int s);
    case (s)
      1: return 15'b110110000000000;
      2: return 15'b101010000000000;
      3: return 15'b000000111010000;
      4: return 15'b001110000001100;
      5: return 15'b001110000001000;
      6, 7: return 15'b001110000000100;
      8: return 15'b000000000000011;
      default: return 15'b0;
    endcase
  endfunction

  function automatic int model_next(input int s, input logic g, input logic [1:0] o);
    if (s == 0) return g ? 1 : 0;
    if (s == 1 || s == 2) return s + 1;
    if (s == 3) return 7 - int'(o);
    if (s >= 4 && s <= 7) return 8;
`ifdef DONE_HOLD_EN
    if (s == 8 && g) return 8;
`endif
    return 0;
  endfunction

  task automatic step(input logic g, input logic [1:0] o);
    int prev;
    go = g;
    op = o;
    @(posedge clk);
    prev = ms;
    ms = model_next(ms, g, o);
    if (ms == 8 && prev != 8) exp_done_edges++;
    @(negedge clk);
    check("cs", 32'(CS), 32'(ms));
    check("vec", 32'(vec), 32'(exp_vec(ms)));
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    ms = 0;
    check("rst_cs", 32'(CS), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] op_tab [4];
    int         cs_tab [4];
    logic [1:0] c_tab  [4];
    op_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
    cs_tab = '{7, 6, 5, 4};
    c_tab  = '{2'b01, 2'b01, 2'b10, 2'b11};

    rst = 1'b1;
    go  = 1'b0;
    op  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cs", 32'(CS), 32'd0);
    check("reset_vec", 32'(vec), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom));

    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'($urandom));
      check("load_a_cs", 32'(CS), 32'd1);
      step(1'b0, 2'($urandom));
      check("load_b_cs", 32'(CS), 32'd2);
      step(1'b0, 2'($urandom));
      check("read_cs", 32'(CS), 32'd3);
      step(1'b0, op_tab[k]);
      check("op_cs", 32'(CS), 32'(cs_tab[k]));
      check("op_c", 32'(C), 32'(c_tab[k]));
      check("op_wa_we", 32'({WA, WE}), 32'b111);
      step(1'b0, 2'($urandom));
      check("done_cs", 32'(CS), 32'd8);
      step(1'b0, 2'($urandom));
      check("idle_cs", 32'(CS), 32'd0);
    end

    for (int i = 0; i < 16; i++) step(1'b1, 2'($urandom));
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);

    step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    check("pre_reset_cs", 32'(CS), 32'd3);
    async_reset();
    step(1'b0, 2'b00);

    for (int i = 0; i < 500; i++) begin
      step(($urandom % 3) != 0, 2'($urandom));
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    check("done_pulses", 32'(obs_done_edges), 32'(exp_done_edges));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_control_unit.md
Name: calc_control_unit

Overview:
- Moore FSM controller for the small calculator datapath (input muxes, 4-entry register file, ALU, output mux).
- On `go`, it sequences the following steps, then pulses `done` and returns to idle:
  - load operand 1 into R1;
  - load operand 2 into R2;
  - read R1 and R2;
  - run the ALU operation selected by `op`;
  - write the result to R3;
  - present the result.
- Exports its current state code for a 7-segment display.

Parameters:
- none (all widths fixed by the datapath)

Ports:
- `clk` input 1: system clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset; forces state 0.
- `go` input 1: start request, sampled in idle.
- `op` input 2: operation select, sampled in state 3.
- `s1` output 2: MUX1 select (input source for register-file write data).
- `WA` output 2: register-file write address.
- `WE` output 1: register-file write enable.
- `RAA` output 2: read address, port A.
- `REA` output 1: read enable, port A.
- `RAB` output 2: read address, port B.
- `REB` output 1: read enable, port B.
- `C` output 2: ALU operation code.
- `s2` output 1: MUX2 select (1 = route result to output).
- `CS` output 4: current state code, 0..8.
- `done` output 1: operation complete.

Behaviour:
- One clock domain. State register is 4 bits, updated on rising `clk`. `rst`=1 clears it to 0 asynchronously, including mid-sequence.
- All outputs are pure combinational decodes of the current state (Moore). No output depends directly on `go` or `op`. `CS` equals the state code.
- Output vector order is {s1,WA,WE,RAA,REA,RAB,REB,C,s2,done}, 15 bits. Values per state:
  - S0 idle: 000000000000000 (this is also the reset value of every output).
  - S1 load A: 110110000000000 (s1=11, WA=01, WE=1).
  - S2 load B: 101010000000000 (s1=10, WA=10, WE=1).
  - S3 read: 000000111010000 (RAA=01, REA=1, RAB=10, REB=1).
  - S4: 001110000001100 (WA=11, WE=1, C=11).
  - S5: 001110000001000 (WA=11, WE=1, C=10).
  - S6: 001110000000100 (WA=11, WE=1, C=01).
  - S7: 001110000000100 (WA=11, WE=1, C=01). Identical to S6 by design.
  - S8 done: 000000000000011 (s2=1, done=1).
- Transitions:
  - S0: go=1 goes to S1; otherwise stay in S0.
  - S1 to S2, and S2 to S3, unconditionally.
  - S3 branches on `op`: 11 to S4, 10 to S5, 01 to S6, 00 to S7.
  - S4 through S7 all go to S8.
  - S8 goes to S0.
- `go` is ignored outside S0. `op` is ignored outside S3; changing it elsewhere has no effect.
- Latency: go sampled in S0, then 5 clocks through S1, S2, S3, the op state and S8, back in S0 on the 6th edge.
- `done` is high for exactly one cycle per operation.
- `go` held high continuously causes back-to-back operations (S8 to S0 to S1).
- Illegal state codes 9..15 (unreachable): all outputs 0; next state is S0.

Optional Feature:
- Macro: `DONE_HOLD_EN`.
- Defined: S8 is held while go=1 and exits to S0 only when go=0. This gives a clean one-operation-per-press handshake; outputs in S8 are unchanged.
- Undefined: S8 always returns to S0 after one cycle, as specified above.

Test Plan:
- Reset:
  - rst=1 asynchronously mid-sequence (e.g. in S3) -> CS=0 immediately;
  - all outputs 000000000000000.
- Idle hold:
  - go=0 for several clocks -> CS stays 0;
  - outputs all 0.
- Start and load:
  - go=1, one clock -> CS=1, vector 110110000000000;
  - next clock -> CS=2, vector 101010000000000;
  - next clock -> CS=3, vector 000000111010000.
- Op decode, for op=00,01,10,11:
  - op set before the S3 edge -> CS=7,6,5,4 respectively;
  - C=01,01,10,11 respectively;
  - WA=11, WE=1.
- Completion:
  - clock from S4..S7 -> CS=8, vector 000000000000011;
  - next clock -> CS=0 (macro off);
  - with `DONE_HOLD_EN` and go=1 -> remains CS=8 until go=0.
- Back-to-back: go held 1 across S8 (macro off) -> S0 then S1 on the next edge; `done` pulses once per op.
